// File: rtl/cnn_pkg.sv
// Shared types and helpers for the convolution front end and layer.
package cnn_pkg;

  // Window feeder control states.
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_e;

  // Default layer geometry.
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_KERNEL_SIZE    = 3;
  localparam int DEF_INPUT_CHANNELS = 3;

  // Window and pixel bus sizes for the default geometry.
  localparam int WIN_ELEMS = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE * DEF_INPUT_CHANNELS;
  localparam int PIX_W     = DEF_INPUT_CHANNELS * DEF_DATA_WIDTH;
  localparam int WIN_W     = WIN_ELEMS * DEF_DATA_WIDTH;

  // Packed element index of (row, col, channel) in a window bus.
  // Row 0 is the oldest image row, col 0 the leftmost column.
  function automatic int win_idx(input int r, input int c, input int ch,
                                 input int ksize, input int nch);
    return (r * ksize + c) * nch + ch;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One circular image-row memory. The read is combinational so the caller
// sees the previous row's pixel in the same cycle it overwrites that slot.
module conv_line_buffer #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[addr];

  // Row storage: cleared on reset, written at the current column on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Raster-order pixel stream to KxKxC sliding windows (stride 1, no padding).
// K-1 line buffers hold the previous rows; a KxK shift register forms the
// window, which doubles as the single output stage.
module conv_window_feeder
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int KERNEL_SIZE    = DEF_KERNEL_SIZE,
  parameter int INPUT_CHANNELS = DEF_INPUT_CHANNELS,
  parameter int IMG_WIDTH      = 32,
  parameter int IMG_HEIGHT     = 32
) (
  input  logic                                                         clk,
  input  logic                                                         rst_n,
  input  logic                                                         clear,
  input  logic                                                         pix_valid,
  output logic                                                         pix_ready,
  input  logic [INPUT_CHANNELS*DATA_WIDTH-1:0]                         pix_data,
  output logic                                                         win_valid,
  input  logic                                                         win_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*INPUT_CHANNELS*DATA_WIDTH-1:0] win_data,
  output logic [$clog2(IMG_HEIGHT)-1:0]                                win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]                                 win_col,
  output logic                                                         frame_done
);

  localparam int PW = INPUT_CHANNELS * DATA_WIDTH;
  localparam int WW = KERNEL_SIZE * KERNEL_SIZE * PW;
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);

  localparam logic [RW-1:0] ROW_K1  = RW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] COL_K1  = CW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);

  feeder_state_e state_q, state_d;
  logic          rdy_en_q, rdy_en_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic          win_valid_q, win_valid_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic [WW-1:0] win_q, win_d;

  logic pix_accept;
  logic win_accept;
  logic col_last;
  logic row_last;
  logic emit;

  logic [PW-1:0] lb_rd   [KERNEL_SIZE-1];
  logic [PW-1:0] col_pix [KERNEL_SIZE];

  assign pix_accept = pix_valid && pix_ready;
  assign win_accept = win_valid_q && win_ready;
  assign col_last   = (col_cnt_q == COL_MAX);
  assign row_last   = (row_cnt_q == ROW_MAX);
  assign emit       = (row_cnt_q >= ROW_K1) && (col_cnt_q >= COL_K1);

  // Line buffer chain: buffer 0 holds the oldest row; each accept moves the
  // column up one buffer and the incoming pixel enters the newest one.
  genvar gi;
  generate
    for (gi = 0; gi < KERNEL_SIZE - 1; gi++) begin : g_lb
      logic [PW-1:0] wr_data;
      if (gi == KERNEL_SIZE - 2) begin : g_newest
        assign wr_data = pix_data;
      end else begin : g_older
        assign wr_data = lb_rd[gi+1];
      end
      conv_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PW)
      ) u_lb (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (pix_accept),
        .addr    (col_cnt_q),
        .wr_data (wr_data),
        .rd_data (lb_rd[gi])
      );
      assign col_pix[gi] = lb_rd[gi];
    end
  endgenerate

  assign col_pix[KERNEL_SIZE-1] = pix_data;

  // State register plus all datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      rdy_en_q    <= 1'b0;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_q       <= '0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= rdy_en_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_q       <= win_d;
    end
  end

  // Next state: windows only form once K-1 rows and columns are buffered;
  // the row wrap always restarts filling since col 0 < K-1.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL, STREAM: begin
          if (pix_accept) begin
            if (row_last && col_last) begin
              state_d = DRAIN;
            end else if (emit && !col_last) begin
              state_d = STREAM;
            end else begin
              state_d = FILL;
            end
          end
        end
        DRAIN: begin
          if (win_accept) begin
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // FSM outputs: input stalls while the window stage is blocked or draining.
  always_comb begin
    pix_ready  = rdy_en_q && !clear && (state_q != DRAIN) &&
                 (!win_valid_q || win_ready);
    frame_done = !clear && (state_q == DRAIN) && win_accept;
  end

  // Counters and window shift register; a window accepted in the same cycle
  // as an emitting pixel is replaced without a bubble.
  always_comb begin
    rdy_en_d    = 1'b1;
    row_cnt_d   = row_cnt_q;
    col_cnt_d   = col_cnt_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_d       = win_q;
    if (clear) begin
      row_cnt_d   = '0;
      col_cnt_d   = '0;
      win_valid_d = 1'b0;
    end else begin
      if (win_accept) begin
        win_valid_d = 1'b0;
      end
      if (pix_accept) begin
        if (col_last) begin
          col_cnt_d = '0;
          row_cnt_d = row_last ? '0 : row_cnt_q + RW'(1);
        end else begin
          col_cnt_d = col_cnt_q + CW'(1);
        end
        for (int r = 0; r < KERNEL_SIZE; r++) begin
          for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
            win_d[win_idx(r, c, 0, KERNEL_SIZE, INPUT_CHANNELS)*DATA_WIDTH +: PW] =
              win_q[win_idx(r, c + 1, 0, KERNEL_SIZE, INPUT_CHANNELS)*DATA_WIDTH +: PW];
          end
          win_d[win_idx(r, KERNEL_SIZE - 1, 0, KERNEL_SIZE, INPUT_CHANNELS)*DATA_WIDTH +: PW] =
            col_pix[r];
        end
        if (emit) begin
          win_valid_d = 1'b1;
          win_row_d   = row_cnt_q - ROW_K1;
          win_col_d   = col_cnt_q - COL_K1;
        end
      end
    end
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: a 4x4 three-channel instance for directed
// scenarios and an 8x6 three-channel instance for random traffic.
module tb_conv_window_feeder;

  localparam int PW = cnn_pkg::PIX_W;
  localparam int WW = cnn_pkg::WIN_W;
  localparam int NE = cnn_pkg::WIN_ELEMS;

  typedef struct {
    logic [WW-1:0] data;
    logic [31:0]   row;
    logic [31:0]   col;
  } exp_t;

  logic clk;
  logic rst_n;

  logic          clear_a, pix_valid_a, pix_ready_a, win_valid_a, win_ready_a, frame_done_a;
  logic [PW-1:0] pix_data_a;
  logic [WW-1:0] win_data_a;
  logic [1:0]    win_row_a, win_col_a;

  logic          clear_b, pix_valid_b, pix_ready_b, win_valid_b, win_ready_b, frame_done_b;
  logic [PW-1:0] pix_data_b;
  logic [WW-1:0] win_data_b;
  logic [2:0]    win_row_b, win_col_b;

  int   nvec = 0;
  int   nerr = 0;
  int   fd_cnt_a = 0;
  int   wins_a = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  logic [PW-1:0] img_b [48];

  conv_window_feeder #(
    .DATA_WIDTH(8), .KERNEL_SIZE(3), .INPUT_CHANNELS(3), .IMG_WIDTH(4), .IMG_HEIGHT(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear_a),
    .pix_valid(pix_valid_a), .pix_ready(pix_ready_a), .pix_data(pix_data_a),
    .win_valid(win_valid_a), .win_ready(win_ready_a), .win_data(win_data_a),
    .win_row(win_row_a), .win_col(win_col_a), .frame_done(frame_done_a)
  );

  conv_window_feeder #(
    .DATA_WIDTH(8), .KERNEL_SIZE(3), .INPUT_CHANNELS(3), .IMG_WIDTH(8), .IMG_HEIGHT(6)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear_b),
    .pix_valid(pix_valid_b), .pix_ready(pix_ready_b), .pix_data(pix_data_b),
    .win_valid(win_valid_b), .win_ready(win_ready_b), .win_data(win_data_b),
    .win_row(win_row_b), .win_col(win_col_b), .frame_done(frame_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // Pixel p of a 4x4 frame: channel ch = 16*ch + base + p.
  function automatic logic [PW-1:0] pix_a(input int base, input int p);
    logic [PW-1:0] v;
    for (int ch = 0; ch < 3; ch++) v[ch*8 +: 8] = 8'(16*ch + base + p);
    return v;
  endfunction

  function automatic logic [WW-1:0] exp_win_a(input int base, input int orow, input int ocol);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        for (int ch = 0; ch < 3; ch++)
          w[((r*3+c)*3+ch)*8 +: 8] = 8'(16*ch + base + (orow+r)*4 + ocol + c);
    return w;
  endfunction

  task automatic push_a(input int base, input int p);
    exp_t e;
    int r, c;
    r = p / 4;
    c = p % 4;
    if (r >= 2 && c >= 2) begin
      e.data = exp_win_a(base, r-2, c-2);
      e.row  = 32'(r-2);
      e.col  = 32'(c-2);
      sb_a.push_back(e);
    end
  endtask

  // One clock of instance A: drive, sample 1 after the falling edge, score.
  task automatic step_a(input logic v, input logic [PW-1:0] d, input logic wr,
                        input logic clr, output logic pacc);
    exp_t e;
    @(negedge clk);
    pix_valid_a = v;
    pix_data_a  = d;
    win_ready_a = wr;
    clear_a     = clr;
    #1;
    pacc = pix_valid_a && pix_ready_a;
    if (frame_done_a) fd_cnt_a++;
    if (win_valid_a && win_ready_a && !clr) begin
      wins_a++;
      nvec++;
      if (sb_a.size() == 0) begin
        nerr++;
        $display("FAIL win_a_unexpected: got window (%0d,%0d), required none", win_row_a, win_col_a);
      end else begin
        e = sb_a.pop_front();
        if (win_data_a !== e.data || 32'(win_row_a) !== e.row || 32'(win_col_a) !== e.col) begin
          nerr++;
          $display("FAIL win_a_data: got (%0d,%0d) %h, required (%0d,%0d) %h",
                   win_row_a, win_col_a, win_data_a, e.row, e.col, e.data);
        end else begin
          $display("win_a (%0d,%0d) %h", win_row_a, win_col_a, win_data_a);
        end
      end
    end
  endtask

  task automatic feed_a(input int base, input int first, input int last);
    int p, guard;
    logic acc;
    p = first;
    guard = 0;
    while (p <= last && guard < 100) begin
      step_a(1'b1, pix_a(base, p), 1'b1, 1'b0, acc);
      if (acc) begin
        push_a(base, p);
        p++;
      end
      guard++;
    end
    nvec++;
    if (p <= last) begin
      nerr++;
      $display("FAIL feed_a_timeout: stuck at pixel %0d, required through %0d", p, last);
    end
  endtask

  task automatic drain_a();
    int guard;
    logic acc;
    guard = 0;
    while (sb_a.size() > 0 && guard < 50) begin
      step_a(1'b0, '0, 1'b1, 1'b0, acc);
      guard++;
    end
    nvec++;
    if (sb_a.size() != 0) begin
      nerr++;
      $display("FAIL drain_a_timeout: got %0d windows outstanding, required 0", sb_a.size());
    end
  endtask

  task automatic check_counts_a(input string name, input int wins, input int fds);
    nvec++;
    if (wins_a != wins || fd_cnt_a != fds) begin
      nerr++;
      $display("FAIL %s_counts: got %0d windows %0d frame_done, required %0d windows %0d frame_done",
               name, wins_a, fd_cnt_a, wins, fds);
    end
  endtask

  task automatic test_reset();
    logic acc;
    repeat (2) @(negedge clk);
    #1;
    nvec++;
    if (pix_ready_a !== 1'b0 || win_valid_a !== 1'b0 || win_data_a !== '0 ||
        win_row_a !== 2'd0 || win_col_a !== 2'd0 || frame_done_a !== 1'b0 ||
        pix_ready_b !== 1'b0 || win_valid_b !== 1'b0) begin
      nerr++;
      $display("FAIL reset_outputs: got rdy=%b val=%b data=%h row=%0d col=%0d fd=%b, required all zero",
               pix_ready_a, win_valid_a, win_data_a, win_row_a, win_col_a, frame_done_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nvec++;
    if (pix_ready_a !== 1'b0) begin
      nerr++;
      $display("FAIL reset_release_ready: got %b before first edge, required 0", pix_ready_a);
    end
    step_a(1'b0, '0, 1'b1, 1'b0, acc);
    nvec++;
    if (pix_ready_a !== 1'b1 || pix_ready_b !== 1'b1) begin
      nerr++;
      $display("FAIL reset_ready_rise: got a=%b b=%b, required 1 1", pix_ready_a, pix_ready_b);
    end
  endtask

  task automatic test_basic();
    logic acc;
    int first0 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    wins_a = 0;
    fd_cnt_a = 0;
    feed_a(0, 0, 10);
    step_a(1'b0, '0, 1'b0, 1'b0, acc);
    nvec++;
    if (win_valid_a !== 1'b1 || win_row_a !== 2'd0 || win_col_a !== 2'd0) begin
      nerr++;
      $display("FAIL basic_first_valid: got val=%b (%0d,%0d), required 1 (0,0)", win_valid_a, win_row_a, win_col_a);
    end
    for (int k = 0; k < 9; k++) begin
      nvec++;
      if (win_data_a[(k*3)*8 +: 8] !== 8'(first0[k])) begin
        nerr++;
        $display("FAIL basic_first_elem%0d: got %0d, required %0d", k, win_data_a[(k*3)*8 +: 8], first0[k]);
      end
    end
    feed_a(0, 11, 15);
    drain_a();
    check_counts_a("basic", 4, 1);
  endtask

  task automatic test_backpressure();
    logic acc;
    wins_a = 0;
    fd_cnt_a = 0;
    feed_a(0, 0, 10);
    for (int i = 0; i < 5; i++) begin
      step_a(1'b1, pix_a(0, 11), 1'b0, 1'b0, acc);
      nvec++;
      if (win_valid_a !== 1'b1 || pix_ready_a !== 1'b0 || win_data_a !== exp_win_a(0, 0, 0)) begin
        nerr++;
        $display("FAIL stall_hold%0d: got val=%b rdy=%b data=%h, required 1 0 %h",
                 i, win_valid_a, pix_ready_a, win_data_a, exp_win_a(0, 0, 0));
      end
    end
    feed_a(0, 11, 15);
    drain_a();
    check_counts_a("backpressure", 4, 1);
  endtask

  task automatic test_back_to_back();
    logic acc;
    int first0 [9] = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
    wins_a = 0;
    fd_cnt_a = 0;
    feed_a(0, 0, 15);
    feed_a(100, 0, 10);
    step_a(1'b0, '0, 1'b0, 1'b0, acc);
    for (int k = 0; k < 9; k++) begin
      nvec++;
      if (win_valid_a !== 1'b1 || win_data_a[(k*3)*8 +: 8] !== 8'(first0[k])) begin
        nerr++;
        $display("FAIL b2b_first_elem%0d: got val=%b %0d, required 1 %0d",
                 k, win_valid_a, win_data_a[(k*3)*8 +: 8], first0[k]);
      end
    end
    feed_a(100, 11, 15);
    drain_a();
    check_counts_a("back_to_back", 8, 2);
  endtask

  task automatic test_channels();
    logic acc;
    wins_a = 0;
    fd_cnt_a = 0;
    feed_a(0, 0, 10);
    step_a(1'b0, '0, 1'b0, 1'b0, acc);
    nvec++;
    if (win_data_a[208 +: 8] !== 8'd42) begin
      nerr++;
      $display("FAIL channels_elem_2_2_2: got %0d, required 42", win_data_a[208 +: 8]);
    end
    nvec++;
    if (win_data_a[0 +: 8] !== 8'd0 || win_data_a[8 +: 8] !== 8'd16 || win_data_a[16 +: 8] !== 8'd32) begin
      nerr++;
      $display("FAIL channels_elem_0_0: got %0d %0d %0d, required 0 16 32",
               win_data_a[0 +: 8], win_data_a[8 +: 8], win_data_a[16 +: 8]);
    end
    feed_a(0, 11, 15);
    drain_a();
    check_counts_a("channels", 4, 1);
  endtask

  task automatic test_clear();
    logic acc;
    wins_a = 0;
    fd_cnt_a = 0;
    feed_a(0, 0, 9);
    step_a(1'b0, '0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, '0, 1'b1, 1'b0, acc);
      nvec++;
      if (win_valid_a !== 1'b0 || pix_ready_a !== 1'b1) begin
        nerr++;
        $display("FAIL clear_idle%0d: got val=%b rdy=%b, required 0 1", i, win_valid_a, pix_ready_a);
      end
    end
    check_counts_a("clear_none", 0, 0);
    feed_a(0, 0, 15);
    drain_a();
    check_counts_a("clear_refill", 4, 1);
  endtask

  task automatic test_reset_mid();
    logic acc;
    feed_a(0, 0, 11);
    @(negedge clk);
    rst_n = 1'b0;
    pix_valid_a = 1'b0;
    #1;
    nvec++;
    if (win_valid_a !== 1'b0 || win_data_a !== '0 || pix_ready_a !== 1'b0 || frame_done_a !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid_outputs: got val=%b data=%h rdy=%b, required 0 0 0",
               win_valid_a, win_data_a, pix_ready_a);
    end
    sb_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step_a(1'b0, '0, 1'b1, 1'b0, acc);
    wins_a = 0;
    fd_cnt_a = 0;
    feed_a(0, 0, 15);
    drain_a();
    check_counts_a("reset_mid", 4, 1);
  endtask

  task automatic test_random();
    int p, guard, wins, fd, q, r, c;
    logic acc, held;
    exp_t e;
    p = 0; guard = 0; wins = 0; fd = 0; held = 1'b0;
    while ((p < 480 || sb_b.size() > 0) && guard < 20000) begin
      @(negedge clk);
      if (!held) begin
        pix_valid_b = (p < 480) && ($urandom_range(0, 1) == 1);
        pix_data_b  = PW'($urandom);
      end
      win_ready_b = ($urandom_range(0, 1) == 1);
      #1;
      acc  = pix_valid_b && pix_ready_b;
      held = pix_valid_b && !acc;
      if (frame_done_b) fd++;
      if (win_valid_b && win_ready_b) begin
        wins++;
        nvec++;
        if (sb_b.size() == 0) begin
          nerr++;
          $display("FAIL win_b_unexpected: got window (%0d,%0d), required none", win_row_b, win_col_b);
        end else begin
          e = sb_b.pop_front();
          if (win_data_b !== e.data || 32'(win_row_b) !== e.row || 32'(win_col_b) !== e.col) begin
            nerr++;
            $display("FAIL win_b_data: got (%0d,%0d) %h, required (%0d,%0d) %h",
                     win_row_b, win_col_b, win_data_b, e.row, e.col, e.data);
          end else begin
            $display("win_b (%0d,%0d) %h", win_row_b, win_col_b, win_data_b);
          end
        end
      end
      if (acc) begin
        q = p % 48;
        r = q / 8;
        c = q % 8;
        img_b[q] = pix_data_b;
        if (r >= 2 && c >= 2) begin
          e.data = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e.data[((i*3+j)*3)*8 +: PW] = img_b[(r-2+i)*8 + (c-2+j)];
          e.row = 32'(r-2);
          e.col = 32'(c-2);
          sb_b.push_back(e);
        end
        p++;
      end
      guard++;
    end
    pix_valid_b = 1'b0;
    nvec++;
    if (p != 480 || sb_b.size() != 0 || wins != 240 || fd != 10 || NE != 27) begin
      nerr++;
      $display("FAIL random_totals: got %0d pixels %0d windows %0d frames %0d pending, required 480 240 10 0",
               p, wins, fd, sb_b.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_a = 1'b0; pix_valid_a = 1'b0; pix_data_a = '0; win_ready_a = 1'b0;
    clear_b = 1'b0; pix_valid_b = 1'b0; pix_data_b = '0; win_ready_b = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_channels();
    test_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
